// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : Oversampling UART receiver. The oversample ratio (x4/x8/x16/x32)
//             and the frame format (5..8 data bits, optional even parity) are
//             latched at the start of each frame. Bits are sampled at mid-bit.
//             Each completed frame produces a one-cycle RX_DONE pulse together
//             with the received word and the parity and framing error flags.
//  Ports    : SCLK    - system clock, rising edge
//             SCLR_N  - asynchronous active-low reset
//             BTICK   - oversample enable, one SCLK-wide pulse per period
//             SAMP    - oversample select (00=x4, 01=x8, 10=x16, 11=x32)
//             UMODE   - [2:1] data bits (00=5..11=8), [0] parity present
//             RX      - serial line, idle high, LSB first
//             RX_DATA - last received word, unused upper bits read 0
//             RX_DONE - one-cycle pulse per completed frame
//             PAR_ERR - parity mismatch on the last frame
//             FRM_ERR - stop bit sampled low on the last frame
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx (
    input  logic       SCLK,
    input  logic       SCLR_N,
    input  logic       BTICK,
    input  logic [1:0] SAMP,
    input  logic [2:0] UMODE,
    input  logic       RX,
    output logic [7:0] RX_DATA,
    output logic       RX_DONE,
    output logic       PAR_ERR,
    output logic       FRM_ERR
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_WAITHI = 3'd5;

    logic       rx_meta;
    logic       rxs;
    logic [2:0] state;
    logic [4:0] cnt;
    logic [2:0] bit_idx;
    logic [1:0] samp_l;
    logic [2:0] umode_l;
    logic [7:0] shreg;
    logic       par_bit;

    logic [4:0] max_cnt;
    logic [4:0] half_cnt;
    logic [2:0] last_idx;
    logic       at_max;

    // Last tick index inside one bit period for the latched oversample ratio.
    always_comb begin
        max_cnt = 5'd3;
        case (samp_l)
            2'b00:   max_cnt = 5'd3;
            2'b01:   max_cnt = 5'd7;
            2'b10:   max_cnt = 5'd15;
            default: max_cnt = 5'd31;
        endcase
    end

    assign half_cnt = max_cnt >> 1;
    // Data bits are 5 + UMODE[2:1], so the last index is 4 + UMODE[2:1].
    assign last_idx = {1'b0, umode_l[2:1]} + 3'd4;
    assign at_max   = (cnt == max_cnt);

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge SCLK or negedge SCLR_N) begin
        if (!SCLR_N) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RX;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge SCLK or negedge SCLR_N) begin
        if (!SCLR_N) begin
            state   <= S_IDLE;
            cnt     <= 5'd0;
            bit_idx <= 3'd0;
            samp_l  <= 2'b00;
            umode_l <= 3'b000;
            shreg   <= 8'h00;
            par_bit <= 1'b0;
            RX_DATA <= 8'h00;
            RX_DONE <= 1'b0;
            PAR_ERR <= 1'b0;
            FRM_ERR <= 1'b0;
        end else begin
            RX_DONE <= 1'b0;
            if (BTICK) begin
                case (state)
                    S_IDLE: begin
                        if (!rxs) begin
                            cnt     <= 5'd0;
                            bit_idx <= 3'd0;
                            samp_l  <= SAMP;
                            umode_l <= UMODE;
                            // Cleared so bits above the data width read 0.
                            shreg   <= 8'h00;
                            par_bit <= 1'b0;
                            state   <= S_START;
                        end
                    end
                    S_START: begin
                        if (cnt == half_cnt) begin
                            cnt     <= 5'd0;
                            bit_idx <= 3'd0;
                            // A line back high at mid-start is a glitch.
                            state   <= rxs ? S_IDLE : S_DATA;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                    S_DATA: begin
                        if (at_max) begin
                            shreg[bit_idx] <= rxs;
                            cnt            <= 5'd0;
                            bit_idx        <= bit_idx + 3'd1;
                            if (bit_idx == last_idx) begin
                                state <= umode_l[0] ? S_PARITY : S_STOP;
                            end
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                    S_PARITY: begin
                        if (at_max) begin
                            par_bit <= rxs;
                            cnt     <= 5'd0;
                            state   <= S_STOP;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                    S_STOP: begin
                        if (at_max) begin
                            cnt     <= 5'd0;
                            RX_DATA <= shreg;
                            // Even parity over the data bits; unused bits are 0.
                            PAR_ERR <= umode_l[0] & (par_bit ^ (^shreg));
                            FRM_ERR <= ~rxs;
                            RX_DONE <= 1'b1;
                            // A low stop bit means a break: wait for the line
                            // to return high before looking for a new start.
                            state   <= rxs ? S_IDLE : S_WAITHI;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                    S_WAITHI: begin
                        if (rxs) begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= 5'd0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx. Directed frames are driven on
//             RX with hand-computed expected results pushed into a queue; a
//             monitor pops one entry for every RX_DONE pulse and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       sclk   = 1'b0;
    logic       sclr_n = 1'b0;
    logic       btick  = 1'b0;
    logic [1:0] samp   = 2'b00;
    logic [2:0] umode  = 3'b000;
    logic       rx     = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       par_err;
    logic       frm_err;

    int checks     = 0;
    int errors     = 0;
    int done_count = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       par;
        logic       frm;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp = '0;

    uart_rx dut (
        .SCLK    (sclk),
        .SCLR_N  (sclr_n),
        .BTICK   (btick),
        .SAMP    (samp),
        .UMODE   (umode),
        .RX      (rx),
        .RX_DATA (rx_data),
        .RX_DONE (rx_done),
        .PAR_ERR (par_err),
        .FRM_ERR (frm_err)
    );

    always #5 sclk = ~sclk;

    // One BTICK every four clocks.
    logic [1:0] div = 2'd0;
    always @(posedge sclk) begin
        div   <= div + 2'd1;
        btick <= (div == 2'd3);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge sclk) begin
        exp_t e;
        if (rx_done === 1'b1) begin
            done_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rx_done: got pulse (data %0h) expected none", rx_data);
            end else begin
                e = sb.pop_front();
                check("rx_data", rx_data, e.data);
                check("par_err", {7'b0, par_err}, {7'b0, e.par});
                check("frm_err", {7'b0, frm_err}, {7'b0, e.frm});
            end
        end
    end

    // Waits for n BTICK edges, then steps #1 past the last one.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sclk);
            while (btick !== 1'b1) @(posedge sclk);
        end
        #1;
    endtask

    task automatic send_frame(input logic [1:0] s, input logic [2:0] m, input logic [7:0] d,
                              input logic pb, input logic stop_bit,
                              input logic [7:0] ed, input logic ep, input logic ef);
        int mx;
        int nb;
        exp_t e;
        mx = 4 << s;
        nb = 5 + int'(m[2:1]);
        e.data = ed;
        e.par  = ep;
        e.frm  = ef;
        sb.push_back(e);
        last_exp = e;
        samp  = s;
        umode = m;
        rx    = 1'b0;
        wait_ticks(mx);
        // Mode inputs must be ignored once the frame has started.
        samp  = ~s;
        umode = ~m;
        for (int i = 0; i < nb; i++) begin
            rx = d[i];
            wait_ticks(mx);
        end
        if (m[0]) begin
            rx = pb;
            wait_ticks(mx);
        end
        rx = stop_bit;
        wait_ticks(mx);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        logic [7:0] partial;

        // Reset state.
        repeat (3) @(posedge sclk);
        #1;
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_done", {7'b0, rx_done}, 8'h00);
        check("reset_par_err", {7'b0, par_err}, 8'h00);
        check("reset_frm_err", {7'b0, frm_err}, 8'h00);
        sclr_n = 1'b1;
        wait_ticks(4);

        // x8, 8 bits + parity: 0xA5 has even weight, parity 0 is correct.
        send_frame(2'b01, 3'b111, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        // 0x01 needs parity 1; sending 0 is an error.
        send_frame(2'b01, 3'b111, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
        // x16, 5 bits, no parity slot.
        send_frame(2'b10, 3'b000, 8'h1F, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0);
        // x32, 6 bits + parity: 0x2D has four ones, parity 0 is correct.
        send_frame(2'b11, 3'b011, 8'h2D, 1'b0, 1'b1, 8'h2D, 1'b0, 1'b0);
        // x4, 7 bits, no parity: upper bit of 0xFF must read 0.
        send_frame(2'b00, 3'b100, 8'hFF, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0);

        // Start glitch of two ticks at x8: rejected, nothing changes.
        dc    = done_count;
        samp  = 2'b01;
        umode = 3'b111;
        rx    = 1'b0;
        wait_ticks(2);
        rx    = 1'b1;
        wait_ticks(40);
        check("glitch_no_done", 8'(done_count), 8'(dc));
        check("glitch_rx_data", rx_data, last_exp.data);
        check("glitch_par_err", {7'b0, par_err}, {7'b0, last_exp.par});
        check("glitch_frm_err", {7'b0, frm_err}, {7'b0, last_exp.frm});

        // Break: stop bit low and line held low, then a normal frame.
        send_frame(2'b00, 3'b110, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        wait_ticks(12);
        rx = 1'b1;
        wait_ticks(4);
        send_frame(2'b00, 3'b110, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);

        // Reset during data bit 3 of a frame.
        partial = 8'h33;
        samp    = 2'b01;
        umode   = 3'b111;
        rx      = 1'b0;
        wait_ticks(8);
        for (int i = 0; i < 4; i++) begin
            rx = partial[i];
            wait_ticks((i == 3) ? 3 : 8);
        end
        #2;
        sclr_n = 1'b0;
        #1;
        check("midreset_rx_data", rx_data, 8'h00);
        check("midreset_rx_done", {7'b0, rx_done}, 8'h00);
        check("midreset_par_err", {7'b0, par_err}, 8'h00);
        check("midreset_frm_err", {7'b0, frm_err}, 8'h00);
        rx = 1'b1;
        repeat (2) @(posedge sclk);
        #3;
        sclr_n = 1'b1;
        wait_ticks(8);
        // 0x5A has four ones, parity 0 is correct.
        send_frame(2'b01, 3'b111, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);

        wait_ticks(8);
        check("scoreboard_drained", 8'(sb.size()), 8'd0);
        check("total_rx_done", 8'(done_count), 8'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: UART_RX

Interface
REQ-001 Port SCLK, input, 1: system clock; all state updates on rising edge.
REQ-002 Port SCLR_N, input, 1: reset, asynchronous assert, active-low; synchronous deassert to SCLK is the integrator's responsibility.
REQ-003 Port BTICK, input, 1: oversample enable, one SCLK-wide pulse per oversample period.
REQ-004 Port SAMP, input, 2: oversample select; 00=x4, 01=x8, 10=x16, 11=x32; MAX = 3/7/15/31.
REQ-005 Port UMODE, input, 3: frame format; UMODE[2:1] = data bits (00=5, 01=6, 10=7, 11=8); UMODE[0]=1 means a parity bit follows the data.
REQ-006 Port RX, input, 1: serial line; idle high; LSB first.
REQ-007 Port RX_DATA, output, 8: last received word; bits above the data width read 0.
REQ-008 Port RX_DONE, output, 1: one-SCLK pulse per completed frame.
REQ-009 Port PAR_ERR, output, 1: parity mismatch on the last frame.
REQ-010 Port FRM_ERR, output, 1: stop bit sampled low on the last frame.

Function
REQ-011 RX shall pass through a 2-flop synchronizer (reset value 1); all decisions shall use the synchronized value rxs.
REQ-012 The FSM shall have states IDLE, START, DATA, PARITY, STOP, WAITHI; all transitions and counter updates shall occur only on SCLK edges with BTICK=1.
REQ-013 IDLE: if rxs=0, clear the sample counter cnt (5 bit), latch SAMP and UMODE, and go to START; mode inputs shall be ignored until the next IDLE exit.
REQ-014 START: increment cnt; when cnt = MAX>>1, go to DATA with cnt=0 and bit index=0 if rxs=0; otherwise go to IDLE (glitch rejection, no flags, no RX_DONE).
REQ-015 DATA: when cnt = MAX, store rxs at the current bit index, clear cnt, and increment the index; otherwise increment cnt.
REQ-016 After the last data bit, DATA shall go to PARITY if latched UMODE[0]=1, else to STOP.
REQ-017 PARITY: when cnt = MAX, sample the parity bit and clear cnt, then go to STOP.
REQ-018 Expected parity shall be even: the XOR of the received data bits only.
REQ-019 STOP: when cnt = MAX, sample the stop bit and update RX_DATA, PAR_ERR (0 when no parity), FRM_ERR (= inverted stop sample), and pulse RX_DONE.
REQ-020 STOP shall go to IDLE if the stop sample=1, else to WAITHI.
REQ-021 WAITHI: remain until rxs=1, then go to IDLE; no RX_DONE is produced (break/line-low handling).
REQ-022 RX_DONE shall be high exactly one SCLK cycle: the cycle after the BTICK edge that sampled the stop bit; RX_DATA, PAR_ERR and FRM_ERR shall be valid in that cycle.
REQ-023 RX_DATA, PAR_ERR and FRM_ERR shall hold their values until the next RX_DONE.
REQ-024 Only the first stop bit shall be checked; extra stop bits are treated as idle line.
REQ-025 Sampling at mid-bit: the start bit is validated at tick MAX>>1, and each subsequent bit is sampled MAX+1 ticks later.

Reset
REQ-026 SCLR_N=0 shall immediately force: state IDLE, cnt=0, bit index=0, synchronizer flops=1, RX_DATA=8'h00, RX_DONE=0, PAR_ERR=0, FRM_ERR=0.
REQ-027 Reset asserted mid-frame shall discard the partial frame; reception shall resume on the first falling edge after release.

Verification
REQ-028 SAMP=01, UMODE=111, frame 0xA5 with parity 0 and stop 1 -> RX_DATA=0xA5, PAR_ERR=0, FRM_ERR=0, one RX_DONE pulse.
REQ-029 SAMP=01, UMODE=111, frame 0x01 with parity bit 0 -> RX_DATA=0x01, PAR_ERR=1, FRM_ERR=0.
REQ-030 SAMP=10, UMODE=000, 5-bit data 5'h1F, stop 1 -> RX_DATA=0x1F, PAR_ERR=0, no parity slot consumed.
REQ-031 SAMP=01, RX low for 2 ticks then high -> FSM back in IDLE, no RX_DONE, outputs unchanged.
REQ-032 SAMP=00, UMODE=110, frame 0x00 with stop 0 (line held low) -> RX_DONE, FRM_ERR=1, FSM in WAITHI until RX returns high; next frame 0x3C is received correctly.
REQ-033 SCLR_N pulsed low during data bit 3 of a frame -> all outputs 0 immediately; the following frame 0x5A yields RX_DATA=0x5A with no errors.
